// File: rtl/fractcam_match_encoder.sv
// Consumer side of the fractcam match interface: tracks issued keys, captures the match
// vector after the array latency and reduces it to the lowest matching entry index.
module fractcam_match_encoder #(
    parameter int TCAM_DEPTH    = 1024,
    parameter int MATCH_LATENCY = 2,
    parameter int SEG_WIDTH     = 32,
    parameter int FIFO_DEPTH    = 8,
    localparam int ADDR_WIDTH   = ($clog2(TCAM_DEPTH) > 1) ? $clog2(TCAM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  search_valid,
    output logic                  search_ready,
    input  logic [TCAM_DEPTH-1:0] match,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_hit,
    output logic                  m_multi
);
    localparam int N_SEG     = TCAM_DEPTH / SEG_WIDTH;
    localparam int SEG_OFF_W = ($clog2(SEG_WIDTH) > 1) ? $clog2(SEG_WIDTH) : 1;
    localparam int SEG_IDX_W = ($clog2(N_SEG) > 1) ? $clog2(N_SEG) : 1;
    localparam int SEG_SHIFT = $clog2(SEG_WIDTH);
    localparam int PTR_W     = ($clog2(FIFO_DEPTH) > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int RES_W     = ADDR_WIDTH + 2;

    if (TCAM_DEPTH % SEG_WIDTH != 0) begin : g_bad_seg
        $error("TCAM_DEPTH must be a multiple of SEG_WIDTH");
    end
    if (MATCH_LATENCY < 1) begin : g_bad_lat
        $error("MATCH_LATENCY must be at least 1");
    end
    if (FIFO_DEPTH < 4) begin : g_bad_fifo
        $error("FIFO_DEPTH must be at least 4");
    end

    // Credits: one per result slot; the array cannot stall, so keys are throttled here.
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             accept;
    logic             pop;

    assign search_ready = (outstanding_q < CNT_W'(FIFO_DEPTH)) && !rst;
    assign accept       = search_valid && search_ready;
    assign pop          = m_valid && m_ready;

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !pop) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (pop && !accept) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    logic [MATCH_LATENCY-1:0] tag_q, tag_d;

    always_comb begin
        tag_d    = tag_q << 1;
        tag_d[0] = accept;
    end

    logic                  cap_valid_q;
    logic [TCAM_DEPTH-1:0] cap_q;

    // Stage 1: per-segment hit, lowest offset and multiple-hit flags.
    logic [N_SEG-1:0]     seg_hit_d, seg_hit_q;
    logic [N_SEG-1:0]     seg_multi_d, seg_multi_q;
    logic [SEG_OFF_W-1:0] seg_off_d [N_SEG];
    logic [SEG_OFF_W-1:0] seg_off_q [N_SEG];
    logic [SEG_WIDTH-1:0] seg_v;
    logic                 s1_valid_q;

    always_comb begin
        seg_v       = '0;
        seg_hit_d   = '0;
        seg_multi_d = '0;
        for (int s = 0; s < N_SEG; s++) begin
            seg_off_d[s]   = '0;
            seg_v          = cap_q[s*SEG_WIDTH +: SEG_WIDTH];
            seg_hit_d[s]   = |seg_v;
            seg_multi_d[s] = |(seg_v & (seg_v - SEG_WIDTH'(1)));
            for (int b = SEG_WIDTH - 1; b >= 0; b--) begin
                if (seg_v[b]) begin
                    seg_off_d[s] = SEG_OFF_W'(b);
                end
            end
        end
    end

    // Stage 2: lowest hitting segment wins; any hit above it makes the result multi.
    logic [SEG_IDX_W-1:0]  sel_seg;
    logic                  s2_hit;
    logic                  s2_multi;
    logic [ADDR_WIDTH-1:0] s2_addr;

    always_comb begin
        sel_seg  = '0;
        s2_hit   = 1'b0;
        s2_multi = 1'b0;
        for (int s = N_SEG - 1; s >= 0; s--) begin
            if (seg_hit_q[s]) begin
                s2_multi = seg_multi_q[s] || s2_hit;
                s2_hit   = 1'b1;
                sel_seg  = SEG_IDX_W'(s);
            end
        end
        s2_addr = s2_hit ? ((ADDR_WIDTH'(sel_seg) << SEG_SHIFT) | ADDR_WIDTH'(seg_off_q[sel_seg]))
                         : '0;
    end

    logic [RES_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic             fifo_wr;
    logic             fifo_rd;
    logic             m_valid_q;
    logic             m_hit_q;
    logic             m_multi_q;
    logic [ADDR_WIDTH-1:0] m_addr_q;

    assign fifo_wr = s1_valid_q;
    assign fifo_rd = (fifo_cnt_q != '0) && (!m_valid_q || m_ready);

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_wr && !fifo_rd) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (fifo_rd && !fifo_wr) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            tag_q         <= '0;
            cap_valid_q   <= 1'b0;
            s1_valid_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            m_valid_q     <= 1'b0;
            m_hit_q       <= 1'b0;
            m_multi_q     <= 1'b0;
            m_addr_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            tag_q         <= tag_d;
            cap_valid_q   <= tag_q[MATCH_LATENCY-1];
            s1_valid_q    <= cap_valid_q;
            fifo_cnt_q    <= fifo_cnt_d;
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_rd) begin
                rd_ptr_q                         <= rd_ptr_q + PTR_W'(1);
                m_valid_q                        <= 1'b1;
                {m_hit_q, m_multi_q, m_addr_q}   <= fifo_mem[rd_ptr_q];
            end else if (pop) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    // Datapath registers carry no reset; their valids qualify them.
    always_ff @(posedge clk) begin
        if (tag_q[MATCH_LATENCY-1]) begin
            cap_q <= match;
        end
        if (cap_valid_q) begin
            seg_hit_q   <= seg_hit_d;
            seg_multi_q <= seg_multi_d;
            seg_off_q   <= seg_off_d;
        end
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q] <= {s2_hit, s2_multi, s2_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fifo_wr && !fifo_rd) begin
            assert (fifo_cnt_q != CNT_W'(FIFO_DEPTH))
            else $error("result FIFO written while full");
        end
    end

    assign m_valid = m_valid_q;
    assign m_hit   = m_hit_q;
    assign m_multi = m_multi_q;
    assign m_addr  = m_addr_q;

endmodule
